mem_wb_pipe: RTL and testbench

- Parametrised memory/writeback pipeline register, DEPTH stages deep, carrying GPR and CSR write channels plus a valid (retire) bit.
- Sits between the memory stage and regfile/csr_file.
- Beyond a plain MEM/WB register it adds:
  - stall hold with duplicate-write suppression;
  - x0 write suppression;
  - a real instret retire pulse;
  - a youngest-match forwarding lookup across all in-flight stages.

---
 rtl/mem_wb_pipe.sv | 117 +++++++++++
 tb/tb_mem_wb_pipe.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_wb_pipe.sv
`default_nettype none
// ============================================================================
// Module      : mem_wb_pipe
// Description : MEM/WB pipeline register, DEPTH stages, with GPR/CSR write
//               channels, stall-safe single retire and youngest-match forwarding.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_wb_pipe #(
  parameter int DEPTH          = 2,
  parameter int RADDR_WIDTH    = 5,
  parameter int DATA_WIDTH     = 32,
  parameter int CSR_ADDR_WIDTH = 12
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      valid_i,
  input  logic [RADDR_WIDTH-1:0]    reg_waddr_i,
  input  logic                      reg_we_i,
  input  logic [DATA_WIDTH-1:0]     reg_wdata_i,
  input  logic                      csr_we_i,
  input  logic [CSR_ADDR_WIDTH-1:0] csr_waddr_i,
  input  logic [DATA_WIDTH-1:0]     csr_wdata_i,
  input  logic                      stall_i,
  input  logic                      flush_i,
  input  logic [RADDR_WIDTH-1:0]    fwd_raddr_i,
  output logic                      fwd_hit_o,
  output logic [DATA_WIDTH-1:0]     fwd_data_o,
  output logic [RADDR_WIDTH-1:0]    reg_waddr_o,
  output logic                      reg_we_o,
  output logic [DATA_WIDTH-1:0]     reg_wdata_o,
  output logic                      csr_we_o,
  output logic [CSR_ADDR_WIDTH-1:0] csr_waddr_o,
  output logic [DATA_WIDTH-1:0]     csr_wdata_o,
  output logic                      instret_incr_o
);

  typedef struct packed {
    logic                      valid;
    logic                      reg_we;
    logic [RADDR_WIDTH-1:0]    reg_waddr;
    logic [DATA_WIDTH-1:0]     reg_wdata;
    logic                      csr_we;
    logic [CSR_ADDR_WIDTH-1:0] csr_waddr;
    logic [DATA_WIDTH-1:0]     csr_wdata;
  } entry_t;

  localparam int     C_LAST   = DEPTH - 1;
  localparam entry_t C_BUBBLE = '0;

  entry_t r_stage [DEPTH];
  entry_t w_src   [DEPTH];
  entry_t w_capture;

  logic                  w_fwd_hit;
  logic [DATA_WIDTH-1:0] w_fwd_data;

  // Write enables are qualified here so later stages never re-check them.
  always_comb begin
    w_capture           = C_BUBBLE;
    w_capture.valid     = valid_i;
    w_capture.reg_we    = reg_we_i & valid_i & (reg_waddr_i != '0);
    w_capture.reg_waddr = reg_waddr_i;
    w_capture.reg_wdata = reg_wdata_i;
    w_capture.csr_we    = csr_we_i & valid_i;
    w_capture.csr_waddr = csr_waddr_i;
    w_capture.csr_wdata = csr_wdata_i;
  end

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    if (k == 0) begin : g_head
      assign w_src[k] = w_capture;
    end else begin : g_body
      assign w_src[k] = r_stage[k-1];
    end

    always_ff @(posedge clk_i) begin
      if (rst_i || flush_i) begin
        r_stage[k] <= C_BUBBLE;
      end else if (stall_i) begin
        // The output stage has already written once; keep its payload but
        // drop the enables so a long stall cannot repeat the write.
        if (k == C_LAST) begin
          r_stage[k].valid  <= 1'b0;
          r_stage[k].reg_we <= 1'b0;
          r_stage[k].csr_we <= 1'b0;
        end
      end else begin
        r_stage[k] <= w_src[k];
      end
    end
  end

  // Scan oldest to youngest so the youngest candidate is the last to win.
  always_comb begin
    w_fwd_hit  = 1'b0;
    w_fwd_data = '0;
    for (int k = C_LAST; k >= 0; k--) begin
      if (r_stage[k].valid && r_stage[k].reg_we &&
          (r_stage[k].reg_waddr == fwd_raddr_i) && (fwd_raddr_i != '0)) begin
        w_fwd_hit  = 1'b1;
        w_fwd_data = r_stage[k].reg_wdata;
      end
    end
  end

  assign fwd_hit_o      = w_fwd_hit;
  assign fwd_data_o     = w_fwd_data;
  assign reg_waddr_o    = r_stage[C_LAST].reg_waddr;
  assign reg_we_o       = r_stage[C_LAST].reg_we;
  assign reg_wdata_o    = r_stage[C_LAST].reg_wdata;
  assign csr_we_o       = r_stage[C_LAST].csr_we;
  assign csr_waddr_o    = r_stage[C_LAST].csr_waddr;
  assign csr_wdata_o    = r_stage[C_LAST].csr_wdata;
  assign instret_incr_o = r_stage[C_LAST].valid;

endmodule
`default_nettype wire

// File: tb/tb_mem_wb_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_wb_pipe
// Description : Self-checking bench for mem_wb_pipe at DEPTH=2 and DEPTH=3.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_wb_pipe;

  logic        clk = 1'b0;
  logic        rst, valid, reg_we, csr_we, stall, flush;
  logic [4:0]  reg_waddr, fwd_raddr;
  logic [31:0] reg_wdata, csr_wdata;
  logic [11:0] csr_waddr;

  logic        o_hit [2], o_we [2], o_cwe [2], o_inc [2];
  logic [31:0] o_fdat [2], o_wdat [2], o_cdat [2];
  logic [4:0]  o_wa [2];
  logic [11:0] o_ca [2];

  int n_cmp = 0;
  int n_bad = 0;
  int n_inc [2] = '{0, 0};

  always #5 clk = ~clk;

  mem_wb_pipe #(.DEPTH(2)) u_dut2 (
    .clk_i(clk), .rst_i(rst), .valid_i(valid), .reg_waddr_i(reg_waddr),
    .reg_we_i(reg_we), .reg_wdata_i(reg_wdata), .csr_we_i(csr_we),
    .csr_waddr_i(csr_waddr), .csr_wdata_i(csr_wdata), .stall_i(stall),
    .flush_i(flush), .fwd_raddr_i(fwd_raddr), .fwd_hit_o(o_hit[0]),
    .fwd_data_o(o_fdat[0]), .reg_waddr_o(o_wa[0]), .reg_we_o(o_we[0]),
    .reg_wdata_o(o_wdat[0]), .csr_we_o(o_cwe[0]), .csr_waddr_o(o_ca[0]),
    .csr_wdata_o(o_cdat[0]), .instret_incr_o(o_inc[0])
  );

  mem_wb_pipe #(.DEPTH(3)) u_dut3 (
    .clk_i(clk), .rst_i(rst), .valid_i(valid), .reg_waddr_i(reg_waddr),
    .reg_we_i(reg_we), .reg_wdata_i(reg_wdata), .csr_we_i(csr_we),
    .csr_waddr_i(csr_waddr), .csr_wdata_i(csr_wdata), .stall_i(stall),
    .flush_i(flush), .fwd_raddr_i(fwd_raddr), .fwd_hit_o(o_hit[1]),
    .fwd_data_o(o_fdat[1]), .reg_waddr_o(o_wa[1]), .reg_we_o(o_we[1]),
    .reg_wdata_o(o_wdat[1]), .csr_we_o(o_cwe[1]), .csr_waddr_o(o_ca[1]),
    .csr_wdata_o(o_cdat[1]), .instret_incr_o(o_inc[1])
  );

  // Model: a list of in-flight instructions, youngest first. An instruction
  // that has already been retired while stalled is marked done.
  typedef struct {
    bit          v, we, cwe, done;
    logic [4:0]  a;
    logic [31:0] d, cd;
    logic [11:0] ca;
  } ent_t;

  ent_t m [2][4];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic model_step();
    ent_t cap;
    cap = '{default: 0};
    cap.v   = valid;
    cap.we  = valid && reg_we && (reg_waddr != 0);
    cap.a   = reg_waddr;
    cap.d   = reg_wdata;
    cap.cwe = valid && csr_we;
    cap.ca  = csr_waddr;
    cap.cd  = csr_wdata;
    for (int u = 0; u < 2; u++) begin
      int dep = u + 2;
      if (rst || flush) begin
        for (int i = 0; i < 4; i++) m[u][i] = '{default: 0};
      end else if (stall) begin
        m[u][dep-1].done = 1;
      end else begin
        for (int i = dep - 1; i > 0; i--) m[u][i] = m[u][i-1];
        m[u][0] = cap;
      end
    end
  endtask

  task automatic model_check();
    for (int u = 0; u < 2; u++) begin
      int   dep = u + 2;
      ent_t b   = m[u][dep-1];
      bit   live = !b.done;
      bit   hit = 0;
      logic [31:0] fd = '0;
      for (int i = 0; i < dep; i++) begin
        if (!hit && m[u][i].v && m[u][i].we && !m[u][i].done &&
            fwd_raddr != 0 && m[u][i].a == fwd_raddr) begin
          hit = 1;
          fd  = m[u][i].d;
        end
      end
      chk($sformatf("d%0d_reg_we", dep),  64'(o_we[u]),   64'(live && b.we));
      chk($sformatf("d%0d_waddr", dep),   64'(o_wa[u]),   64'(b.a));
      chk($sformatf("d%0d_wdata", dep),   64'(o_wdat[u]), 64'(b.d));
      chk($sformatf("d%0d_csr_we", dep),  64'(o_cwe[u]),  64'(live && b.cwe));
      chk($sformatf("d%0d_csr_addr", dep), 64'(o_ca[u]),  64'(b.ca));
      chk($sformatf("d%0d_csr_data", dep), 64'(o_cdat[u]), 64'(b.cd));
      chk($sformatf("d%0d_instret", dep), 64'(o_inc[u]),  64'(live && b.v));
      chk($sformatf("d%0d_fwd_hit", dep), 64'(o_hit[u]),  64'(hit));
      chk($sformatf("d%0d_fwd_data", dep), 64'(o_fdat[u]), 64'(fd));
      if (o_inc[u] === 1'b1) n_inc[u]++;
    end
  endtask

  initial begin
    for (int u = 0; u < 2; u++)
      for (int i = 0; i < 4; i++) m[u][i] = '{default: 0};
    forever begin
      @(posedge clk);
      model_step();
      #1;
      model_check();
    end
  end

  task automatic set_in(input bit v, input bit we, input logic [4:0] a,
                        input logic [31:0] d, input bit cwe,
                        input logic [11:0] ca, input logic [31:0] cd);
    valid = v; reg_we = we; reg_waddr = a; reg_wdata = d;
    csr_we = cwe; csr_waddr = ca; csr_wdata = cd;
  endtask

  task automatic idle();
    set_in(0, 0, 5'd0, 32'd0, 0, 12'd0, 32'd0);
  endtask

  task automatic cyc(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_zero(input int u);
    chk($sformatf("zero_d%0d_we", u + 2),    64'(o_we[u]),   64'd0);
    chk($sformatf("zero_d%0d_waddr", u + 2), 64'(o_wa[u]),   64'd0);
    chk($sformatf("zero_d%0d_wdata", u + 2), 64'(o_wdat[u]), 64'd0);
    chk($sformatf("zero_d%0d_csr", u + 2),   64'(o_cwe[u]),  64'd0);
    chk($sformatf("zero_d%0d_inc", u + 2),   64'(o_inc[u]),  64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    rst = 1; stall = 0; flush = 0; fwd_raddr = 0;
    idle();
    cyc(2);
    chk_zero(0);
    chk_zero(1);
    rst = 0;

    // 1: basic write with DEPTH latency
    set_in(1, 1, 5'd5, 32'hDEAD_BEEF, 0, 12'd0, 32'd0);
    cyc(); idle();
    cyc();
    chk("t1_we",    64'(o_we[0]),   64'd1);
    chk("t1_waddr", 64'(o_wa[0]),   64'd5);
    chk("t1_wdata", 64'(o_wdat[0]), 64'hDEADBEEF);
    chk("t1_inc",   64'(o_inc[0]),  64'd1);
    cyc();
    chk("t1_inc_once", 64'(o_inc[0]), 64'd0);
    chk("t1_d3_we",    64'(o_we[1]),  64'd1);
    cyc(2);

    // 2: write to x0 retires but never writes or forwards
    set_in(1, 1, 5'd0, 32'h1234, 0, 12'd0, 32'd0);
    fwd_raddr = 5'd0;
    cyc(); idle();
    chk("t2_fwd0_hit", 64'(o_hit[0]), 64'd0);
    cyc();
    chk("t2_we",  64'(o_we[0]),  64'd0);
    chk("t2_inc", 64'(o_inc[0]), 64'd1);
    cyc(2);
    chk("t2_cnt2", 64'(n_inc[0]), 64'd2);

    // 3: stall with output entry held, writes exactly once
    set_in(1, 1, 5'd7, 32'hA5A5_A5A5, 0, 12'd0, 32'd0);
    cyc();
    set_in(1, 1, 5'd8, 32'h0000_0088, 0, 12'd0, 32'd0);
    cyc();
    chk("t3_a_we", 64'(o_we[0]), 64'd1);
    chk("t3_a_wa", 64'(o_wa[0]), 64'd7);
    idle(); stall = 1;
    cyc();
    chk("t3_hold_we",   64'(o_we[0]),   64'd0);
    chk("t3_hold_data", 64'(o_wdat[0]), 64'hA5A5A5A5);
    chk("t3_hold_inc",  64'(o_inc[0]),  64'd0);
    cyc(2);
    chk("t3_hold_wa", 64'(o_wa[0]), 64'd7);
    stall = 0;
    cyc();
    chk("t3_b_we", 64'(o_we[0]), 64'd1);
    chk("t3_b_wa", 64'(o_wa[0]), 64'd8);
    cyc();
    chk("t3_b_once", 64'(o_we[0]), 64'd0);
    cyc(2);
    chk("t3_cnt2", 64'(n_inc[0]), 64'd4);
    chk("t3_cnt3", 64'(n_inc[1]), 64'd4);

    // 4: flush beats stall and discards the CSR input
    set_in(1, 1, 5'd9, 32'h99, 0, 12'd0, 32'd0);
    cyc();
    set_in(1, 1, 5'd10, 32'hAA, 0, 12'd0, 32'd0);
    cyc();
    set_in(1, 0, 5'd0, 32'd0, 1, 12'h300, 32'h8);
    flush = 1; stall = 1;
    cyc();
    idle(); flush = 0; stall = 0;
    chk_zero(0);
    chk_zero(1);
    cyc(4);
    chk("t4_cnt2", 64'(n_inc[0]), 64'd5);
    chk("t4_cnt3", 64'(n_inc[1]), 64'd4);

    // 5: youngest match wins, then flush removes all candidates
    set_in(1, 1, 5'd3, 32'h11, 0, 12'd0, 32'd0);
    cyc();
    set_in(1, 1, 5'd4, 32'h44, 0, 12'd0, 32'd0);
    cyc();
    set_in(1, 1, 5'd3, 32'h22, 0, 12'd0, 32'd0);
    fwd_raddr = 5'd3;
    cyc();
    idle();
    chk("t5_hit3",  64'(o_hit[1]),  64'd1);
    chk("t5_data3", 64'(o_fdat[1]), 64'h22);
    chk("t5_hit2",  64'(o_hit[0]),  64'd1);
    chk("t5_data2", 64'(o_fdat[0]), 64'h22);
    flush = 1;
    cyc();
    flush = 0;
    chk("t5_fl_hit",  64'(o_hit[1]),  64'd0);
    chk("t5_fl_data", 64'(o_fdat[1]), 64'd0);
    fwd_raddr = 5'd0;
    cyc(2);

    // 6: reset during stall, then normal latency afterwards
    set_in(1, 1, 5'd12, 32'h5555, 1, 12'h301, 32'h3);
    cyc(); idle();
    cyc(); stall = 1;
    cyc(); rst = 1;
    cyc();
    chk_zero(0);
    chk_zero(1);
    rst = 0; stall = 0;
    set_in(1, 1, 5'd13, 32'h77, 0, 12'd0, 32'd0);
    cyc(); idle();
    chk("t6_d2_early", 64'(o_we[0]), 64'd0);
    cyc();
    chk("t6_d2_we",   64'(o_we[0]),   64'd1);
    chk("t6_d2_data", 64'(o_wdat[0]), 64'h77);
    chk("t6_d3_early", 64'(o_we[1]),  64'd0);
    cyc();
    chk("t6_d3_we", 64'(o_we[1]), 64'd1);
    chk("t6_d3_wa", 64'(o_wa[1]), 64'd13);
    cyc(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
